pto_profile_gen: RTL

Parametrised pulse-train output (PTO) generator for stepper/servo step-direction drives. It emits a trapezoidal or triangular velocity profile: accelerate from `period_max_us`, cruise, then decelerate symmetrically. The block adds a start/busy/done handshake, a latched direction output, abort and configurable widths. It sits between the motion-command registers and the drive's STEP/DIR pins, one instance per axis.

---
 rtl/pto_profile_gen.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pto_profile_gen.sv
// pto_profile_gen: step/direction pulse-train generator with a trapezoidal or
// triangular velocity profile, start/busy/done handshake, abort and latched DIR.
module pto_profile_gen #(
  parameter int CLK_PER_US = 50,
  parameter int W          = 32,
  parameter int PW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          dir_in,
  input  logic [W-1:0]  total_pulses,
  input  logic [W-1:0]  accel_pulses,
  input  logic [PW-1:0] period_max_us,
  input  logic [PW-1:0] period_min_us,
  input  logic [PW-1:0] step_us,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          pto_out,
  output logic          dir_out,
  output logic [W-1:0]  pulse_count,
  output logic [PW-1:0] period_now
);

  localparam int PSW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int XW  = W + PW;

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

  // Ramp distance of pulse idx from the nearest end of the move (0 at either end,
  // capped at ramp in the cruise section); DECEL is the mirror image of ACCEL.
  function automatic logic [PW-1:0] periodCalc(
    input logic [W-1:0]  idx,
    input logic [W-1:0]  tot,
    input logic [W-1:0]  ramp,
    input logic [PW-1:0] pmax,
    input logic [PW-1:0] pmin,
    input logic [PW-1:0] step
  );
    logic [W-1:0]  k;
    logic [XW-1:0] prod;
    logic [XW-1:0] diff;
    if (idx < ramp) k = idx;
    else if (idx < tot - ramp) k = ramp;
    else k = tot - idx - W'(1);
    prod = XW'(k) * XW'(step);
    if (prod >= XW'(pmax)) diff = '0;
    else diff = XW'(pmax) - prod;
    if (diff < XW'(pmin)) return pmin;
    return PW'(diff);
  endfunction

  function automatic state_t stateCalc(
    input logic [W-1:0] idx,
    input logic [W-1:0] tot,
    input logic [W-1:0] ramp
  );
    if (idx < ramp) return ACCEL;
    if (idx < tot - ramp) return CRUISE;
    return DECEL;
  endfunction

  state_t         state_q;
  logic [PSW-1:0] prescale_q;
  logic [PW-1:0]  usCnt_q;
  logic           pto_q;
  logic           busy_q;
  logic           done_q;
  logic           aborted_q;
  logic           dir_q;
  logic [W-1:0]   count_q;
  logic [PW-1:0]  period_q;
  logic [W-1:0]   total_q;
  logic [W-1:0]   ramp_q;
  logic [PW-1:0]  pmax_q;
  logic [PW-1:0]  pmin_q;
  logic [PW-1:0]  step_q;

  logic [PW-1:0]  pmaxClamp;
  logic [PW-1:0]  pminTmp;
  logic [PW-1:0]  pminClamp;
  logic [W-1:0]   rampClamp;
  logic [W-1:0]   nextIdx;
  logic [PW-1:0]  nextPeriod;
  logic [PW-1:0]  firstPeriod;
  logic [PW-1:0]  phaseUs;
  logic           usTick;
  logic           phaseEnd;

  // Command clamps, next-pulse period and microsecond/phase timing decode.
  always_comb begin
    pmaxClamp   = (period_max_us < PW'(2)) ? PW'(2) : period_max_us;
    pminTmp     = (period_min_us < PW'(2)) ? PW'(2) : period_min_us;
    pminClamp   = (pminTmp > pmaxClamp) ? pmaxClamp : pminTmp;
    rampClamp   = (accel_pulses < (total_pulses >> 1)) ? accel_pulses : (total_pulses >> 1);
    nextIdx     = count_q + W'(1);
    nextPeriod  = periodCalc(nextIdx, total_q, ramp_q, pmax_q, pmin_q, step_q);
    firstPeriod = periodCalc(W'(0), total_pulses, rampClamp, pmaxClamp, pminClamp, step_us);
    phaseUs     = pto_q ? (period_q >> 1) : (period_q - (period_q >> 1));
    usTick      = (prescale_q == PSW'(CLK_PER_US - 1));
    phaseEnd    = usTick && (usCnt_q == (phaseUs - PW'(1)));
  end

  // Move sequencer: start handshake, abort, low/high phases and pulse counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prescale_q <= '0;
      usCnt_q    <= '0;
      pto_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      dir_q      <= 1'b0;
      count_q    <= '0;
      period_q   <= '0;
      total_q    <= '0;
      ramp_q     <= '0;
      pmax_q     <= '0;
      pmin_q     <= '0;
      step_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          dir_q      <= dir_in;
          count_q    <= '0;
          aborted_q  <= 1'b0;
          prescale_q <= '0;
          usCnt_q    <= '0;
          pto_q      <= 1'b0;
          total_q    <= total_pulses;
          ramp_q     <= rampClamp;
          pmax_q     <= pmaxClamp;
          pmin_q     <= pminClamp;
          step_q     <= step_us;
          if (total_pulses == '0) begin
            done_q <= 1'b1;
          end else begin
            busy_q   <= 1'b1;
            period_q <= firstPeriod;
            state_q  <= stateCalc(W'(0), total_pulses, rampClamp);
          end
        end
      end else if (abort) begin
        pto_q     <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
        state_q   <= IDLE;
      end else begin
        prescale_q <= usTick ? '0 : prescale_q + PSW'(1);
        if (phaseEnd) begin
          usCnt_q <= '0;
          if (!pto_q) begin
            pto_q <= 1'b1;
          end else begin
            pto_q   <= 1'b0;
            count_q <= nextIdx;
            if (nextIdx == total_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              period_q <= nextPeriod;
              state_q  <= stateCalc(nextIdx, total_q, ramp_q);
            end
          end
        end else if (usTick) begin
          usCnt_q <= usCnt_q + PW'(1);
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pto_out     = pto_q;
  assign dir_out     = dir_q;
  assign pulse_count = count_q;
  assign period_now  = period_q;

endmodule
